// File: rtl/pll_lock_supervisor.sv
// PLL reset-and-lock supervisor: pulses the PLL reset, qualifies lock over a
// stability window, releases the system reset, and retries or faults on timeout.
module pll_lock_supervisor #(
    parameter int RST_PULSE    = 16,
    parameter int LOCK_TIMEOUT = 50000,
    parameter int STABLE       = 1024,
    parameter int MAX_RETRY    = 7,
    parameter int CNT_W        = 16
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       pll_locked,
    output logic       pll_rst,
    output logic       sys_rst,
    output logic       ready,
    output logic       fault,
    output logic [3:0] retry_cnt,
    output logic [7:0] lock_loss_cnt
);

    typedef enum logic [2:0] {
        S_RESET_PLL,
        S_WAIT_LOCK,
        S_STABILIZE,
        S_READY,
        S_FAULT
    } state_t;

    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_PULSE - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE - 1);
    localparam logic [3:0]       RETRY_LIM    = 4'(MAX_RETRY);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [3:0]       retry_nxt;
    logic [7:0]       loss_nxt;
    logic [1:0]       sync_q;
    logic             locked_s;

    // pll_locked comes from the PLL output domain; only the second flop is used.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], pll_locked};
        end
    end

    assign locked_s = sync_q[1];

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state         <= S_RESET_PLL;
            cnt           <= '0;
            retry_cnt     <= '0;
            lock_loss_cnt <= '0;
            pll_rst       <= 1'b1;
            sys_rst       <= 1'b1;
            ready         <= 1'b0;
            fault         <= 1'b0;
        end else begin
            state         <= state_nxt;
            cnt           <= cnt_nxt;
            retry_cnt     <= retry_nxt;
            lock_loss_cnt <= loss_nxt;
            pll_rst       <= (state_nxt == S_RESET_PLL);
            sys_rst       <= (state_nxt != S_READY);
            ready         <= (state_nxt == S_READY);
            fault         <= (state_nxt == S_FAULT);
        end
    end

    always_comb begin
        state_nxt = state;
        retry_nxt = retry_cnt;
        loss_nxt  = lock_loss_cnt;
        cnt_nxt   = cnt;
        case (state)
            S_RESET_PLL: begin
                if (cnt == RST_LAST) state_nxt = S_WAIT_LOCK;
            end
            S_WAIT_LOCK: begin
                // A lock seen in the same cycle as the timeout wins.
                if (locked_s) begin
                    state_nxt = S_STABILIZE;
                end else if (cnt == TIMEOUT_LAST) begin
                    if (retry_cnt == RETRY_LIM) begin
                        state_nxt = S_FAULT;
                    end else begin
                        retry_nxt = retry_cnt + 4'd1;
                        state_nxt = S_RESET_PLL;
                    end
                end
            end
            S_STABILIZE: begin
                if (!locked_s) begin
                    state_nxt = S_WAIT_LOCK;
                end else if (cnt == STABLE_LAST) begin
                    state_nxt = S_READY;
                end
            end
            S_READY: begin
                if (!locked_s) begin
                    loss_nxt  = (lock_loss_cnt == 8'hFF) ? lock_loss_cnt
                                                         : lock_loss_cnt + 8'd1;
                    retry_nxt = '0;
                    state_nxt = S_RESET_PLL;
                end
            end
            S_FAULT: begin
                state_nxt = S_FAULT;
            end
            default: begin
                state_nxt = S_RESET_PLL;
            end
        endcase

        // READY and FAULT never look at the counter, so it is parked there.
        if (state_nxt != state) begin
            cnt_nxt = '0;
        end else if (state == S_READY || state == S_FAULT) begin
            cnt_nxt = cnt;
        end else begin
            cnt_nxt = cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Self-checking bench for pll_lock_supervisor: directed scenarios with literal
// timing checks plus randomized lock traffic compared against a timestamp model.
module tb_pll_lock_supervisor;

    localparam int RST_PULSE    = 4;
    localparam int LOCK_TIMEOUT = 20;
    localparam int STABLE       = 8;
    localparam int MAX_RETRY    = 2;

    localparam int PH_PULSE = 0;
    localparam int PH_SEEK  = 1;
    localparam int PH_QUAL  = 2;
    localparam int PH_UP    = 3;
    localparam int PH_DEAD  = 4;

    logic       refclk = 1'b0;
    logic       rst;
    logic       pll_locked;
    logic       pll_rst;
    logic       sys_rst;
    logic       ready;
    logic       fault;
    logic [3:0] retry_cnt;
    logic [7:0] lock_loss_cnt;

    int  errors   = 0;
    int  checks   = 0;
    bit  check_en = 1'b0;

    int   ph      = PH_PULSE;
    int   entered = 0;
    int   retries = 0;
    int   losses  = 0;
    int   edge_n  = 0;
    logic hist[$];

    pll_lock_supervisor #(
        .RST_PULSE   (RST_PULSE),
        .LOCK_TIMEOUT(LOCK_TIMEOUT),
        .STABLE      (STABLE),
        .MAX_RETRY   (MAX_RETRY),
        .CNT_W       (8)
    ) dut (
        .refclk       (refclk),
        .rst          (rst),
        .pll_locked   (pll_locked),
        .pll_rst      (pll_rst),
        .sys_rst      (sys_rst),
        .ready        (ready),
        .fault        (fault),
        .retry_cnt    (retry_cnt),
        .lock_loss_cnt(lock_loss_cnt)
    );

    always #5 refclk = ~refclk;

    task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s at edge %0d: got %0d, expected %0d", name, edge_n, act, exp);
        end
    endtask

    task automatic model_reset();
        ph      = PH_PULSE;
        entered = 0;
        retries = 0;
        losses  = 0;
        edge_n  = 0;
        hist    = {1'b0, 1'b0};
    endtask

    // Reference model: each phase is timed by the edge at which it was entered;
    // the synchronizer is a two-deep queue of sampled lock values.
    always @(posedge refclk or posedge rst) begin
        if (rst) begin
            model_reset();
        end else begin
            logic ls;
            int   age;
            edge_n++;
            ls = hist.pop_front();
            hist.push_back(pll_locked);
            age = edge_n - entered;
            case (ph)
                PH_PULSE: if (age == RST_PULSE) begin ph = PH_SEEK; entered = edge_n; end
                PH_SEEK: begin
                    if (ls) begin
                        ph = PH_QUAL; entered = edge_n;
                    end else if (age == LOCK_TIMEOUT) begin
                        if (retries == MAX_RETRY) ph = PH_DEAD;
                        else begin retries++; ph = PH_PULSE; end
                        entered = edge_n;
                    end
                end
                PH_QUAL: begin
                    if (!ls) begin ph = PH_SEEK; entered = edge_n; end
                    else if (age == STABLE) begin ph = PH_UP; entered = edge_n; end
                end
                PH_UP: if (!ls) begin
                    losses  = (losses < 255) ? losses + 1 : 255;
                    retries = 0;
                    ph      = PH_PULSE;
                    entered = edge_n;
                end
                default: ;
            endcase
        end
    end

    always @(negedge refclk) begin
        if (check_en) begin
            checkOutput("model_pll_rst",   pll_rst,       8'(ph == PH_PULSE));
            checkOutput("model_sys_rst",   sys_rst,       8'(ph != PH_UP));
            checkOutput("model_ready",     ready,         8'(ph == PH_UP));
            checkOutput("model_fault",     fault,         8'(ph == PH_DEAD));
            checkOutput("model_retry_cnt", retry_cnt,     8'(retries));
            checkOutput("model_loss_cnt",  lock_loss_cnt, 8'(losses));
        end
    end

    task automatic goto_edge(input int n);
        int guard = 0;
        while (edge_n < n && guard < 20000) begin
            @(negedge refclk);
            guard++;
        end
        if (edge_n < n) checkOutput("goto_edge_timeout", 8'(edge_n), 8'(n));
    endtask

    task automatic applyStimulus(input logic lk, input int ncyc);
        pll_locked = lk;
        repeat (ncyc) @(negedge refclk);
    endtask

    task automatic wait_ready(input logic level, input int budget);
        int n = 0;
        while (ready !== level && n < budget) begin
            @(negedge refclk);
            n++;
        end
        checkOutput("ready_wait", 8'(ready), 8'(level));
    endtask

    task automatic check_reset_values(input string tag);
        checkOutput({tag, "_pll_rst"}, pll_rst,       8'd1);
        checkOutput({tag, "_sys_rst"}, sys_rst,       8'd1);
        checkOutput({tag, "_ready"},   ready,         8'd0);
        checkOutput({tag, "_fault"},   fault,         8'd0);
        checkOutput({tag, "_retry"},   retry_cnt,     8'd0);
        checkOutput({tag, "_loss"},    lock_loss_cnt, 8'd0);
    endtask

    task automatic async_reset_now();
        @(posedge refclk);
        #2;
        rst = 1'b1;
        #1;
    endtask

    task automatic release_reset();
        @(negedge refclk);
        rst = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        pll_locked = 1'b0;
        repeat (3) @(negedge refclk);
        check_reset_values("por");
        check_en = 1'b1;

        // Lock arrives between edges 10 and 11, qualified after edge 21.
        release_reset();
        goto_edge(3);  checkOutput("s1_pll_rst_e3", pll_rst, 8'd1);
        goto_edge(4);  checkOutput("s1_pll_rst_e4", pll_rst, 8'd0);
        goto_edge(10); pll_locked = 1'b1;
        goto_edge(20); checkOutput("s1_ready_e20", ready, 8'd0);
        goto_edge(21);
        checkOutput("s1_ready_e21",   ready,     8'd1);
        checkOutput("s1_sys_rst_e21", sys_rst,   8'd0);
        checkOutput("s1_retry_e21",   retry_cnt, 8'd0);

        // Lock loss first sampled at edge 26, reacted to at edge 28.
        goto_edge(25); pll_locked = 1'b0;
        goto_edge(27); checkOutput("s4_ready_e27", ready, 8'd1);
        goto_edge(28);
        checkOutput("s4_sys_rst_e28", sys_rst,       8'd1);
        checkOutput("s4_ready_e28",   ready,         8'd0);
        checkOutput("s4_pll_rst_e28", pll_rst,       8'd1);
        checkOutput("s4_loss_e28",    lock_loss_cnt, 8'd1);
        checkOutput("s4_retry_e28",   retry_cnt,     8'd0);
        goto_edge(31); checkOutput("s4_pll_rst_e31", pll_rst, 8'd1);
        goto_edge(32); checkOutput("s4_pll_rst_e32", pll_rst, 8'd0);
        pll_locked = 1'b1;
        goto_edge(42); checkOutput("s4_ready_e42", ready, 8'd0);
        goto_edge(43); checkOutput("s4_ready_e43", ready, 8'd1);

        // Second loss, then a 2-cycle dropout during qualification at cnt=5.
        goto_edge(45); pll_locked = 1'b0;
        goto_edge(52); pll_locked = 1'b1;
        goto_edge(58); pll_locked = 1'b0;
        goto_edge(60); pll_locked = 1'b1;
        goto_edge(63); checkOutput("s3_ready_e63", ready, 8'd0);
        goto_edge(70); checkOutput("s3_ready_e70", ready, 8'd0);
        goto_edge(71);
        checkOutput("s3_ready_e71", ready,         8'd1);
        checkOutput("s3_loss_e71",  lock_loss_cnt, 8'd2);
        checkOutput("s3_retry_e71", retry_cnt,     8'd0);

        // Asynchronous reset in the middle of WAIT_LOCK with one retry used.
        pll_locked = 1'b0;
        async_reset_now();
        check_reset_values("s5_ready");
        release_reset();
        goto_edge(24); checkOutput("s5_retry_e24", retry_cnt, 8'd1);
        goto_edge(30); checkOutput("s5_pll_rst_e30", pll_rst, 8'd0);
        async_reset_now();
        check_reset_values("s5_wait");

        // No lock ever: three pulses, then a sticky fault.
        release_reset();
        goto_edge(4);  checkOutput("s2_pll_rst_e4",  pll_rst,   8'd0);
        goto_edge(24);
        checkOutput("s2_pll_rst_e24", pll_rst,   8'd1);
        checkOutput("s2_retry_e24",   retry_cnt, 8'd1);
        goto_edge(28); checkOutput("s2_pll_rst_e28", pll_rst, 8'd0);
        goto_edge(48);
        checkOutput("s2_pll_rst_e48", pll_rst,   8'd1);
        checkOutput("s2_retry_e48",   retry_cnt, 8'd2);
        goto_edge(51); checkOutput("s2_pll_rst_e51", pll_rst, 8'd1);
        goto_edge(52); checkOutput("s2_pll_rst_e52", pll_rst, 8'd0);
        goto_edge(71); checkOutput("s2_fault_e71", fault, 8'd0);
        goto_edge(72);
        checkOutput("s2_fault_e72",   fault,   8'd1);
        checkOutput("s2_pll_rst_e72", pll_rst, 8'd0);
        checkOutput("s2_sys_rst_e72", sys_rst, 8'd1);
        checkOutput("s2_ready_e72",   ready,   8'd0);
        goto_edge(75); pll_locked = 1'b1;
        goto_edge(95);
        checkOutput("s2_fault_e95", fault, 8'd1);
        checkOutput("s2_ready_e95", ready, 8'd0);
        async_reset_now();
        check_reset_values("s5_fault");

        // 257 lock losses through READY; the counter must saturate at 255.
        pll_locked = 1'b0;
        release_reset();
        for (int i = 0; i < 257; i++) begin
            applyStimulus(1'b1, 1);
            wait_ready(1'b1, 80);
            applyStimulus(1'b0, 1);
            wait_ready(1'b0, 20);
            if (i == 0) checkOutput("s6_loss_first", lock_loss_cnt, 8'd1);
            if (i == 254) checkOutput("s6_loss_255", lock_loss_cnt, 8'd255);
        end
        checkOutput("s6_loss_sat", lock_loss_cnt, 8'd255);

        // Randomized lock traffic with occasional asynchronous resets.
        for (int s = 0; s < 400; s++) begin
            if ($urandom_range(0, 39) == 0) begin
                async_reset_now();
                check_reset_values("rnd_rst");
                pll_locked = 1'(($urandom_range(0, 1)));
                release_reset();
            end else begin
                applyStimulus(1'(($urandom_range(0, 2) != 0)), $urandom_range(1, 45));
            end
        end

        @(negedge refclk);
        check_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
